// File: rtl/array_queue_ctrl_pkg.sv
// array_queue_ctrl_pkg: shared sizing constants for the array-backed queue controller.
package array_queue_ctrl_pkg;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_WIDTH     = 80;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_PTR_W     = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W     = $clog2(DEF_DEPTH + 1);
endpackage

// File: rtl/array_queue_ctrl.sv
// array_queue_ctrl: ready/valid FIFO sequencing a 1R1W array with a registered-address read port,
// re-reading the head every cycle so the one-cycle read latency stays hidden.
module array_queue_ctrl
    import array_queue_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             arr_w_en,
    output logic [PW-1:0]    arr_w_addr,
    output logic [WIDTH-1:0] arr_w_data,
    output logic             arr_r_en,
    output logic [PW-1:0]    arr_r_addr,
    input  logic [WIDTH-1:0] arr_r_data
);
    logic [PW-1:0] wptr, rptr, rptr_n;
    logic [CW-1:0] cnt;
    logic          head_valid, enq_fire, deq_fire;

    // reset gates enq_ready so nothing is accepted while the async reset is held
    always_comb begin
        enq_ready   = !reset && !flush && (cnt != CW'(DEPTH));
        deq_valid   = head_valid && !flush;
        enq_fire    = enq_valid && enq_ready;
        deq_fire    = deq_valid && deq_ready;
        rptr_n      = rptr + PW'(deq_fire);
        arr_w_en    = enq_fire;
        arr_w_addr  = wptr;
        arr_w_data  = enq_bits;
        arr_r_addr  = rptr_n;
        arr_r_en    = !flush && ((cnt - CW'(deq_fire)) != '0);
        deq_bits    = arr_r_data;
        count       = cnt;
        almost_full = cnt >= CW'(AF_THRESH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
        end else begin
            wptr       <= wptr + PW'(enq_fire);
            rptr       <= rptr_n;
            cnt        <= cnt + CW'(enq_fire) - CW'(deq_fire);
            head_valid <= arr_r_en;
        end
    end
endmodule

// File: tb/tb_array_queue_ctrl.sv
// tb_array_queue_ctrl: drives the queue controller against a behavioural 8x80 array model
// and checks dequeued data in order through a scoreboard.
module tb_array_queue_ctrl;
    localparam int W = 80;

    logic         clock = 1'b0, reset = 1'b1, flush = 1'b0;
    logic         enq_valid = 1'b0, deq_ready = 1'b0;
    logic [W-1:0] enq_bits = '0;
    logic         enq_ready, deq_valid, almost_full;
    logic [W-1:0] deq_bits, arr_w_data, arr_r_data;
    logic [3:0]   count;
    logic         arr_w_en, arr_r_en;
    logic [2:0]   arr_w_addr, arr_r_addr;

    logic [W-1:0] mem [8];
    logic [W-1:0] sb [$];
    int tests = 0, fails = 0, popped = 0;

    array_queue_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count), .almost_full(almost_full),
        .arr_w_en(arr_w_en), .arr_w_addr(arr_w_addr), .arr_w_data(arr_w_data),
        .arr_r_en(arr_r_en), .arr_r_addr(arr_r_addr), .arr_r_data(arr_r_data)
    );

    always #5 clock = ~clock;

    // array model: registered-address read, random garbage when not enabled
    always @(posedge clock) begin
        if (arr_w_en) mem[arr_w_addr] <= arr_w_data;
        arr_r_data <= arr_r_en ? mem[arr_r_addr] : {16'($urandom), $urandom, $urandom};
    end

    always @(negedge clock) begin
        if (reset) begin
        end else if (flush) begin
            sb.delete();
        end else begin
            if (deq_valid && deq_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL deq_underflow: got %h, expected nothing", deq_bits);
                end else begin
                    logic [W-1:0] e;
                    e = sb.pop_front();
                    popped++;
                    if (deq_bits !== e) begin
                        fails++;
                        $display("FAIL deq_data: got %h, expected %h", deq_bits, e);
                    end
                end
            end
            if (enq_valid && enq_ready) sb.push_back(enq_bits);
        end
    end

    function automatic logic [W-1:0] mk(input int i);
        return {16'hBEEF, 32'(i), 32'(i) ^ 32'h0000_DEAD};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        while (count != 0 && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (count !== 4'd0) begin
            fails++;
            $display("FAIL drain_timeout: count %0d, expected 0", count);
        end
        deq_ready = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({enq_ready, deq_valid, arr_w_en, arr_r_en, almost_full} !== 5'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL %s: rdy/vld/wen/ren/af=%b count=%0d, expected 00000 count=0", tag,
                     {enq_ready, deq_valid, arr_w_en, arr_r_en, almost_full}, count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enq_valid = 1'b1;
        enq_bits = mk(999);
        tick();
        tick();
        check_reset_outputs("reset_outputs");
        enq_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_latency();
        tick();
        enq_valid = 1'b1;
        enq_bits = 80'hA5;
        @(negedge clock);
        tests++;
        if (enq_ready !== 1'b1) begin
            fails++;
            $display("FAIL lat_enq_ready: got %b, expected 1", enq_ready);
        end
        tick();
        enq_valid = 1'b0;
        @(negedge clock);
        tests++;
        if (deq_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_early_valid: got %b, expected 0 at t+1", deq_valid);
        end
        tick();
        @(negedge clock);
        tests++;
        if (deq_valid !== 1'b1 || deq_bits !== 80'hA5 || count !== 4'd1) begin
            fails++;
            $display("FAIL lat_t2: valid=%b bits=%h count=%0d, expected 1 a5 1", deq_valid, deq_bits, count);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        @(negedge clock);
        tests++;
        if (deq_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL lat_empty: valid=%b count=%0d, expected 0 0", deq_valid, count);
        end
    endtask

    task automatic test_fill();
        tick();
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int e;
            e = (i < 8) ? i : 8;
            enq_bits = mk(100 + i);
            @(negedge clock);
            tests++;
            if (count !== 4'(e) || almost_full !== (e >= 6) || enq_ready !== (e != 8)) begin
                fails++;
                $display("FAIL fill_%0d: count=%0d af=%b rdy=%b, expected %0d %b %b", i, count,
                         almost_full, enq_ready, e, e >= 6, e != 8);
            end
            tick();
        end
        enq_valid = 1'b0;
    endtask

    task automatic test_full_stream();
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            enq_bits = mk(200 + k);
            @(negedge clock);
            tests++;
            // full blocks enq even while dequeuing, so the occupancy settles one below full
            if (deq_valid !== 1'b1 || count !== ((k == 0) ? 4'd8 : 4'd7) || enq_ready !== (k != 0)) begin
                fails++;
                $display("FAIL stream_%0d: valid=%b count=%0d rdy=%b, expected 1 %0d %b", k, deq_valid,
                         count, enq_ready, (k == 0) ? 8 : 7, k != 0);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int sent = 0, n = 0, base;
        logic fired;
        base = popped;
        enq_valid = 1'b1;
        enq_bits = mk(1000);
        while (sent < 100 && n < 1000) begin
            deq_ready = n[0];
            @(negedge clock);
            fired = enq_valid && enq_ready;
            tick();
            n++;
            if (fired) begin
                sent++;
                enq_bits = mk(1000 + sent);
            end
        end
        drain();
        tests++;
        if (popped - base !== 100 || sb.size() != 0) begin
            fails++;
            $display("FAIL toggle_total: popped %0d left %0d, expected 100 0", popped - base, sb.size());
        end
    endtask

    task automatic test_flush();
        enq_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_bits = mk(300 + i);
            tick();
        end
        enq_valid = 1'b0;
        tick();
        @(negedge clock);
        tests++;
        if (count !== 4'd5 || deq_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre: count=%0d valid=%b, expected 5 1", count, deq_valid);
        end
        tick();
        flush = 1'b1;
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        @(negedge clock);
        tests++;
        if ({enq_ready, deq_valid, arr_w_en, arr_r_en} !== 4'b0) begin
            fails++;
            $display("FAIL flush_during: rdy/vld/wen/ren=%b, expected 0000", {enq_ready, deq_valid, arr_w_en, arr_r_en});
        end
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        @(negedge clock);
        tests++;
        if (count !== 4'd0 || deq_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_after: count=%0d valid=%b, expected 0 0", count, deq_valid);
        end
        tick();
        enq_valid = 1'b1;
        enq_bits = 80'h3C;
        tick();
        enq_valid = 1'b0;
        tick();
        @(negedge clock);
        tests++;
        if (deq_valid !== 1'b1 || deq_bits !== 80'h3C) begin
            fails++;
            $display("FAIL flush_reenq: valid=%b bits=%h, expected 1 3c", deq_valid, deq_bits);
        end
        drain();
    endtask

    task automatic test_async_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_bits = mk(400 + i);
            tick();
        end
        enq_valid = 1'b1;
        enq_bits = mk(499);
        tests++;
        if (count !== 4'd4) begin
            fails++;
            $display("FAIL areset_pre: count=%0d, expected 4", count);
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("areset_immediate");
        sb.delete();
        enq_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        enq_valid = 1'b1;
        enq_bits = 80'h77;
        tick();
        enq_valid = 1'b0;
        tests++;
        if (count !== 4'd1) begin
            fails++;
            $display("FAIL areset_count: count=%0d, expected 1", count);
        end
        tick();
        @(negedge clock);
        tests++;
        if (deq_valid !== 1'b1 || deq_bits !== 80'h77) begin
            fails++;
            $display("FAIL areset_reenq: valid=%b bits=%h, expected 1 77", deq_valid, deq_bits);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_full_stream();
        test_back_to_back();
        test_flush();
        test_async_reset();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
